div_32bit: RTL and testbench

Sequential 32-bit radix-2 non-restoring divider. It is the inverse operation to the arithmetic unit's 32-bit Booth multiplier: given dividend and divisor, it produces quotient and remainder. It sits beside the multiplier in the ArithmeticUnit and is driven by the ALU control through a start/done handshake. It takes one iteration per clock, so the datapath is a single adder/subtractor rather than an unrolled array.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 28 ++
 rtl/div_32bit.sv | 144 ++++++++++++++
 tb/tb_div_32bit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// Optional feature macro: DIV_SIGNED_EN (signed two's-complement division).
package div_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam logic [WIDTH-1:0] DBZ_QUOT = 32'hFFFF_FFFF;

  // Absolute value of a two's-complement operand; 32'h8000_0000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 non-restoring iteration: shift {P,Q} left,
// add or subtract the divisor depending on the sign of P, record the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W:0]   p,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   p_next,
  output logic [W-1:0] q_next
);

  logic [W:0] shifted;

  // Add/subtract choice uses the sign of P before the shift.
  always_comb begin
    shifted = {p[W-1:0], q[W-1]};
    if (p[W]) begin
      p_next = shifted + {1'b0, d};
    end else begin
      p_next = shifted - {1'b0, d};
    end
    q_next = {q[W-2:0], ~p_next[W]};
  end

endmodule

// File: rtl/div_32bit.sv
// Sequential 32-bit radix-2 non-restoring divider with start/done handshake.
// Optional feature macro: DIV_SIGNED_EN (signed division, quotient truncates
// toward zero, remainder takes the dividend's sign). Undefined: unsigned.
module div_32bit
#(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  import div_pkg::*;

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic             res_dbz;

  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  div_step #(.W(WIDTH)) u_step (
    .p      (p),
    .q      (q),
    .d      (d),
    .p_next (p_step),
    .q_next (q_step)
  );

`ifdef DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;

  // Signed build: iterate on magnitudes, then restore signs in FIX.
  always_comb begin
    mag_a   = magnitude(dividend);
    mag_b   = magnitude(divisor);
    rem_mag = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
    fix_q   = q_neg ? (~q + 1'b1) : q;
    fix_r   = r_neg ? (~rem_mag + 1'b1) : rem_mag;
  end
`else
  // Unsigned build: operands go straight into the datapath.
  always_comb begin
    mag_a   = dividend;
    mag_b   = divisor;
    rem_mag = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
    fix_q   = q;
    fix_r   = rem_mag;
  end
`endif

  // Control FSM, iteration counter, operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      res_q       <= '0;
      res_r       <= '0;
      res_dbz     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            p    <= '0;
            q    <= mag_a;
            d    <= mag_b;
`ifdef DIV_SIGNED_EN
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              res_q   <= DBZ_QUOT;
              res_r   <= dividend;
              res_dbz <= 1'b1;
              state   <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          p   <= p_step;
          q   <= q_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          res_q   <= fix_q;
          res_r   <= fix_r;
          res_dbz <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          quotient    <= res_q;
          remainder   <= res_r;
          div_by_zero <= res_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit.sv
// Self-checking bench for div_32bit; honours DIV_SIGNED_EN like the RTL.
module tb_div_32bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          accept;
  } exp_t;

  exp_t scoreboard[$];

  int cycle     = 0;
  int done_seen = 0;
  int checks    = 0;
  int errors    = 0;

  div_32bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cycle);
    end
  endtask

  // Reference model of the divider result, independent of the RTL structure.
  task automatic modelDiv(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eq, output logic [31:0] er, output logic edbz);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    sa  = a;
    sbv = b;
    edbz = 1'b0;
    if (b == 32'd0) begin
      eq   = 32'hFFFF_FFFF;
      er   = a;
      edbz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        eq = 32'h8000_0000;
        er = 32'd0;
      end else begin
        eq = sa / sbv;
        er = sa % sbv;
      end
`else
      eq = a / b;
      er = a % b;
`endif
    end
  endtask

  // Drive one start pulse at the current negedge and record what must come back.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eq, input logic [31:0] er,
                               input logic edbz, input int lat);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q      = eq;
    e.r      = er;
    e.dbz    = edbz;
    e.lat    = lat;
    e.accept = cycle + 1;
    scoreboard.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Wait (bounded) until every pending result has been seen.
  task automatic waitDone();
    for (int i = 0; i < 80 && scoreboard.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 64'(scoreboard.size()), 64'd0);
  endtask

  // Result monitor: samples just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cycle++;
    if (done) begin
      done_seen++;
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = scoreboard.pop_front();
        checkOutput("quotient", 64'(quotient), 64'(e.q));
        checkOutput("remainder", 64'(remainder), 64'(e.r));
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        checkOutput("latency", 64'(cycle - e.accept), 64'(e.lat));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
      end
    end else if (scoreboard.size() != 0 && cycle >= scoreboard[0].accept) begin
      checkOutput("busy_during_op", 64'(busy), 64'd1);
    end
  end

  // Directed sequence followed by a few random operations.
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edbz;
    int          base;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_quotient", 64'(quotient), 64'd0);
    checkOutput("rst_remainder", 64'(remainder), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    waitDone();

`ifdef DIV_SIGNED_EN
    applyStimulus(32'hFFFF_FF8D, 32'hFFFF_FFDA, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);
    waitDone();
    applyStimulus(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    waitDone();
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
    waitDone();
`else
    applyStimulus(32'hFFFF_FF8D, 32'hFFFF_FFDA, 32'd0, 32'hFFFF_FF8D, 1'b0, 34);
    waitDone();
    applyStimulus(32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0, 34);
    waitDone();
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);
    waitDone();
`endif

    applyStimulus(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    waitDone();
    applyStimulus(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
    waitDone();

    // Start pulsed mid-operation must be ignored; next start lands in the done cycle.
    applyStimulus(32'd77, 32'd7, 32'd11, 32'd0, 1'b0, 34);
    repeat (9) @(negedge clk);
    dividend = 32'd1;
    divisor  = 32'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_mid", 64'(busy), 64'd1);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    applyStimulus(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34);
    waitDone();

    // Reset at cycle 20 of an operation aborts it.
    applyStimulus(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    scoreboard.delete();
    base = done_seen;
    @(negedge clk);
    checkOutput("abort_quotient", 64'(quotient), 64'd0);
    checkOutput("abort_remainder", 64'(remainder), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("no_done_after_abort", 64'(done_seen - base), 64'd0);

    applyStimulus(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 34);
    waitDone();

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 1) ? 32'($urandom_range(1, 255)) : $urandom;
      modelDiv(a, b, eq, er, edbz);
      applyStimulus(a, b, eq, er, edbz, edbz ? 1 : 34);
      waitDone();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
